// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg: shared AES types, S-box/Rcon tables and key-size lookups. Rev 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    KL128 = 2'd0,
    KL192 = 2'd1,
    KL256 = 2'd2
  } key_len_e;

  typedef enum logic [2:0] {
    S_NOKEY  = 3'd0,
    S_EXPAND = 3'd1,
    S_IDLE   = 3'd2,
    S_RUN    = 3'd3,
    S_HOLD   = 3'd4
  } aes_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Padded to 16 entries so any 4-bit index stays in range.
  localparam logic [0:15][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL128:   return 4'd10;
      KL192:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL128:   return 4'd4;
      KL192:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_round_core: one combinational AES round; is_final skips MixColumns. Rev 1.0
// ---------------------------------------------------------------------------
module aes_round_core
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key,
  input  logic   is_final,
  output block_t state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    sb = '{default: 8'h00};
    sr = '{default: 8'h00};
    mc = '{default: 8'h00};
    state_out = '0;
    for (int n = 0; n < 16; n++) begin
      sb[n] = sbox(state_in[127-8*n -: 8]);
    end
    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int n = 0; n < 16; n++) begin
      state_out[127-8*n -: 8] = (is_final ? sr[n] : mc[n]) ^ round_key[127-8*n -: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_iter_encrypt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_iter_encrypt: iterative AES-128/192/256 encryptor, UNROLL rounds/clock. Rev 1.0
// ---------------------------------------------------------------------------
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int DBG_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  output logic         key_load_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state
);

  aes_state_e st;
  key_len_e   kl;
  key_len_e   new_kl;
  // Power-of-two depth keeps every {round,2'bxx} index inside the array.
  word_t      rk [64];
  logic [5:0] widx;
  logic [2:0] kmod;
  logic [3:0] rcidx;
  logic [3:0] round;
  block_t     sreg;

  logic [3:0] nk;
  logic [3:0] nr;
  logic [5:0] w_last;
  logic       load_fire;
  logic       last_step;
  word_t      w_prev;
  word_t      w_back;
  word_t      w_temp;
  word_t      w_new;
  block_t     chain [UNROLL+1];

  assign key_load_ready = (st == S_NOKEY) || (st == S_IDLE);
  assign in_ready       = (st == S_IDLE) && !key_load;
  assign load_fire      = key_load && key_load_ready;
  assign nk             = nk_of(kl);
  assign nr             = nr_of(kl);
  assign w_last         = {nr + 4'd1, 2'b00} - 6'd1;

  always_comb begin
    case (key_len)
      2'd0:    new_kl = KL128;
      2'd1:    new_kl = KL192;
      default: new_kl = KL256;
    endcase
  end

  always_comb begin
    w_prev = rk[widx - 6'd1];
    w_back = rk[widx - {2'b00, nk}];
    if (kmod == 3'd0) begin
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {RCON[rcidx], 24'h000000};
    end else if (nk == 4'd8 && kmod == 3'd4) begin
      w_temp = sub_word(w_prev);
    end else begin
      w_temp = w_prev;
    end
    w_new = w_back ^ w_temp;
  end

  always_ff @(posedge clk) begin
    if (rst_n && load_fire) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk_of(new_kl))) rk[j] <= key[255-32*j -: 32];
      end
    end else if (rst_n && st == S_EXPAND) begin
      rk[widx] <= w_new;
    end
  end

  assign chain[0] = sreg;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [3:0] rnd;
    block_t     rkey;
    assign rnd  = round + 4'(k);
    assign rkey = {rk[{rnd, 2'd0}], rk[{rnd, 2'd1}], rk[{rnd, 2'd2}], rk[{rnd, 2'd3}]};
    aes_round_core u_core (
      .state_in  (chain[k]),
      .round_key (rkey),
      .is_final  (rnd == nr),
      .state_out (chain[k+1])
    );
  end

  assign last_step = (round + 4'(UNROLL - 1)) == nr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_NOKEY;
      kl        <= KL128;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      cipher    <= '0;
      round     <= '0;
      sreg      <= '0;
      widx      <= '0;
      kmod      <= '0;
      rcidx     <= '0;
    end else begin
      case (st)
        S_NOKEY, S_IDLE: begin
          if (key_load) begin
            kl        <= new_kl;
            key_ready <= 1'b0;
            widx      <= {2'b00, nk_of(new_kl)};
            kmod      <= 3'd0;
            rcidx     <= 4'd0;
            st        <= S_EXPAND;
          end else if (st == S_IDLE && in_valid) begin
            sreg  <= plain ^ {rk[0], rk[1], rk[2], rk[3]};
            round <= 4'd1;
            st    <= S_RUN;
          end
        end
        S_EXPAND: begin
          widx  <= widx + 6'd1;
          rcidx <= (kmod == 3'd0) ? rcidx + 4'd1 : rcidx;
          kmod  <= (kmod == 3'(nk - 4'd1)) ? 3'd0 : kmod + 3'd1;
          if (widx == w_last) begin
            key_ready <= 1'b1;
            st        <= S_IDLE;
          end
        end
        S_RUN: begin
          sreg  <= chain[UNROLL];
          round <= round + 4'(UNROLL);
          if (last_step) begin
            cipher    <= chain[UNROLL];
            out_valid <= 1'b1;
            st        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= S_IDLE;
          end
        end
        default: st <= S_NOKEY;
      endcase
    end
  end

  if (DBG_EN != 0) begin : g_dbg
    assign dbg_round = round;
    assign dbg_state = sreg;
  end else begin : g_nodbg
    assign dbg_round = 4'd0;
    assign dbg_state = '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_encrypt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_iter_encrypt: directed FIPS-197 vectors on UNROLL=1 and UNROLL=2 DUTs. Rev 1.0
// ---------------------------------------------------------------------------
module tb_aes_iter_encrypt;

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefdeadbeefdeadbeefdeadbeef};
  localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hffffffffffffffff};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic [127:0] plain = '0;

  logic         klr1, kr1, ir1, ov1, klr2, kr2, ir2, ov2;
  logic [127:0] c1, c2, ds1, ds2;
  logic [3:0]   dr1, dr2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_iter_encrypt #(.UNROLL(1), .DBG_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_load_ready(klr1),
    .key_len(key_len), .key(key), .key_ready(kr1), .in_valid(in_valid),
    .in_ready(ir1), .plain(plain), .out_valid(ov1), .out_ready(out_ready),
    .cipher(c1), .dbg_round(dr1), .dbg_state(ds1)
  );

  aes_iter_encrypt #(.UNROLL(2), .DBG_EN(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_load_ready(klr2),
    .key_len(key_len), .key(key), .key_ready(kr2), .in_valid(in_valid),
    .in_ready(ir2), .plain(plain), .out_valid(ov2), .out_ready(out_ready),
    .cipher(c2), .dbg_round(dr2), .dbg_state(ds2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [1:0] len, input logic [255:0] k, output int lat);
    int n;
    n = 0;
    while (!(klr1 && klr2) && n < 50) begin tick(); n++; end
    key_len  = len;
    key      = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 1;
    while (!kr1 && n < 200) begin tick(); n++; end
    lat = n;
    check("key_ready_u2", 128'(kr2), 128'(1));
  endtask

  task automatic encrypt(input logic [127:0] p, output logic [127:0] o1, output logic [127:0] o2,
                         output int l1, output int l2);
    int n;
    bit d1, d2;
    n = 0;
    while (!(ir1 && ir2) && n < 50) begin tick(); n++; end
    plain    = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0; d1 = 0; d2 = 0; l1 = 0; l2 = 0; o1 = '0; o2 = '0;
    while (!(d1 && d2) && n < 40) begin
      tick();
      n++;
      if (ov1 && !d1) begin d1 = 1; l1 = n; o1 = c1; end
      if (ov2 && !d2) begin d2 = 1; l2 = n; o2 = c2; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, l1, l2, n;
    logic [127:0] o1, o2;
    bit seen;

    tick(); tick();
    check("rst_key_ready", 128'(kr1), 128'(0));
    check("rst_in_ready", 128'(ir1), 128'(0));
    check("rst_key_load_ready", 128'(klr1), 128'(1));
    check("rst_out_valid", 128'(ov1), 128'(0));
    check("rst_cipher", c1, 128'h0);
    check("rst_dbg_round", 128'(dr1), 128'(0));
    check("rst_dbg_state", ds1, 128'h0);
    rst_n = 1'b1;
    tick();

    load_key(2'd0, KEY_B, lat);
    check("b_key_lat", 128'(lat), 128'(41));
    encrypt(PT_B, o1, o2, l1, l2);
    check("b_cipher_u1", o1, CT_B);
    check("b_cipher_u2", o2, CT_B);
    check("b_lat_u1", 128'(l1), 128'(10));
    check("b_lat_u2", 128'(l2), 128'(5));

    load_key(2'd1, KEY_C2, lat);
    check("c2_key_lat", 128'(lat), 128'(47));
    encrypt(PT_C, o1, o2, l1, l2);
    check("c2_cipher_u1", o1, CT_C2);
    check("c2_cipher_u2", o2, CT_C2);
    check("c2_lat_u1", 128'(l1), 128'(12));
    check("c2_lat_u2", 128'(l2), 128'(6));

    load_key(2'd2, KEY_C3, lat);
    check("c3_key_lat", 128'(lat), 128'(53));
    encrypt(PT_C, o1, o2, l1, l2);
    check("c3_cipher_u1", o1, CT_C3);
    check("c3_cipher_u2", o2, CT_C3);
    check("c3_lat_u1", 128'(l1), 128'(14));
    check("c3_lat_u2", 128'(l2), 128'(7));

    // Backpressure with ignored re-key attempts, then key reuse.
    load_key(2'd0, KEY_C1, lat);
    check("c1_key_lat", 128'(lat), 128'(41));
    tick();
    out_ready = 1'b0;
    plain     = PT_C;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!ov1 && n < 40) begin tick(); n++; end
    check("bp_out_valid", 128'(ov1), 128'(1));
    key_load = 1'b1;
    key_len  = 2'd2;
    key      = KEY_C3;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_cipher_u1", c1, CT_C1);
      check("bp_cipher_u2", c2, CT_C1);
      check("bp_in_ready", 128'(ir1 || ir2), 128'(0));
      check("bp_key_load_ready", 128'(klr1 || klr2), 128'(0));
      check("bp_out_valid_held", 128'(ov1 && ov2), 128'(1));
    end
    key_load  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", 128'(ov1 || ov2), 128'(0));
    check("bp_key_kept", 128'(kr1 && kr2), 128'(1));
    encrypt(PT_C, o1, o2, l1, l2);
    check("reuse_cipher_u1", o1, CT_C1);
    check("reuse_cipher_u2", o2, CT_C1);
    check("reuse_lat_u1", 128'(l1), 128'(10));

    // Reset in the middle of a run.
    tick();
    plain    = PT_C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (dr1 != 4'd5 && n < 20) begin tick(); n++; end
    check("rr_round5", 128'(dr1), 128'(5));
    check("rr_nodbg_round", 128'(dr2), 128'(0));
    check("rr_nodbg_state", ds2, 128'h0);
    rst_n = 1'b0;
    tick();
    check("rr_out_valid", 128'(ov1 || ov2), 128'(0));
    check("rr_key_ready", 128'(kr1 || kr2), 128'(0));
    check("rr_key_load_ready", 128'(klr1 && klr2), 128'(1));
    check("rr_in_ready", 128'(ir1 || ir2), 128'(0));
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ov1 || ov2) seen = 1;
    end
    check("rr_no_output", 128'(seen), 128'(0));
    load_key(2'd3, KEY_C3, lat);
    check("rr_key_lat", 128'(lat), 128'(53));
    encrypt(PT_C, o1, o2, l1, l2);
    check("rr_cipher_u1", o1, CT_C3);
    check("rr_cipher_u2", o2, CT_C3);

    // Simultaneous key_load and in_valid: re-key wins.
    tick();
    key_len  = 2'd0;
    key      = KEY_B;
    key_load = 1'b1;
    plain    = PT_B;
    in_valid = 1'b1;
    #1;
    check("sim_in_ready", 128'(ir1 || ir2), 128'(0));
    check("sim_key_load_ready", 128'(klr1 && klr2), 128'(1));
    tick();
    key_load = 1'b0;
    in_valid = 1'b0;
    check("sim_key_ready_low", 128'(kr1 || kr2), 128'(0));
    check("sim_not_accepted", 128'(ir1 || ir2 || klr1 || klr2), 128'(0));
    n = 1;
    while (!kr1 && n < 200) begin tick(); n++; end
    check("sim_key_lat", 128'(n), 128'(41));
    encrypt(PT_B, o1, o2, l1, l2);
    check("sim_cipher_u1", o1, CT_B);
    check("sim_cipher_u2", o2, CT_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_iter_encrypt.md
Name: aes_iter_encrypt

Overview:
- Sequential, parametrised successor to the fully-unrolled combinational AES-256 encryptor.
- Supports AES-128, AES-192 and AES-256, selected at run time.
- Expands the key once into an internal round-key store, then encrypts any number of blocks under that key, processing UNROLL rounds per clock.
- Uses valid/ready handshakes on input and output; sits between the block-cipher mode controller and the output FIFO.

Parameters:
- UNROLL, 1: rounds computed per clock; legal values 1 or 2, since Nr = 10/12/14 are all even.
- DBG_EN, 1: when 0, dbg_round and dbg_state are tied to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- key_load  in  1  start key expansion; accepted only when key_load_ready=1
- key_load_ready  out  1  high in states NOKEY and IDLE
- key_len  in  2  0=128, 1=192, 2=256, 3 treated as 256; sampled with key_load
- key  in  256  user key, left-aligned: 128-bit key in [255:128], 192-bit key in [255:64]; unused LSBs ignored
- key_ready  out  1  key schedule valid
- in_valid  in  1  plaintext valid
- in_ready  out  1  high only in state IDLE
- plain  in  128  plaintext block
- out_valid  out  1  cipher valid
- out_ready  in  1  consumer ready
- cipher  out  128  ciphertext; held stable while out_valid=1
- dbg_round  out  4  current round index
- dbg_state  out  128  state register after the last completed round

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM goes to NOKEY.
  - Reset values: key_ready=0, in_ready=0, key_load_ready=1, out_valid=0, cipher=0, dbg_round=0, dbg_state=0.
  - The round-key store is not cleared, but key_ready=0 makes it unused.
  - Reset mid-expansion or mid-encryption aborts the operation with no output.
- FSM states: NOKEY, EXPAND, IDLE, RUN, HOLD.
- NOKEY --key_load--> EXPAND.
- EXPAND:
  - On entry, copy Nk words of the key into rk[0..Nk-1]. Nk = 4/6/8; Nr = 10/12/14.
  - Generate one 32-bit word w[i] per clock for i = Nk .. 4(Nr+1)-1, per FIPS-197:
    - RotWord, SubWord and Rcon applied when i mod Nk = 0.
    - SubWord only, when Nk=8 and i mod 8 = 4.
  - Expansion takes 40 / 46 / 52 cycles for 128 / 192 / 256. Then go to IDLE with key_ready=1.
- IDLE:
  - in_valid & in_ready: state <= plain ^ rk[0..3], round <= 1, go to RUN.
  - Otherwise, key_load with key_ready deasserted goes to EXPAND (re-key).
  - Simultaneous in_valid and key_load: key_load wins; in_ready is low that cycle.
- RUN:
  - Each clock applies UNROLL rounds: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - MixColumns is omitted in round Nr.
  - round += UNROLL. After round Nr is applied: cipher <= result, out_valid <= 1, go to HOLD.
  - Latency: out_valid rises Nr/UNROLL clocks after the accepting edge (10/12/14 for UNROLL=1; 5/6/7 for UNROLL=2).
  - key_load is ignored in RUN and HOLD (key_load_ready=0).
- HOLD:
  - cipher and out_valid are held until out_ready=1; that edge clears out_valid and goes to IDLE.
  - No overlap: the next block is accepted no earlier than the clock after the output handshake. Back-to-back throughput is one block per Nr/UNROLL + 2 clocks.
- key_len is latched at key_load; later changes on the key_len input have no effect until the next re-key.
- All byte ordering follows FIPS-197: byte 0 = bits [127:120]; column-major state.

Decomposition:
- Package aes_pkg holds:
  - the S-box function and the Rcon table;
  - the key_len_e enum (KL128, KL192, KL256);
  - the NR and NK lookup functions;
  - the FSM state enum;
  - the word_t and block_t typedefs.
- Sub-module aes_round_core: combinational single round with an is_final input that bypasses MixColumns. Instantiate it UNROLL times in a chain.
- Key-word generation stays inline in the top module.

Test Plan:
- FIPS-197 App. B: key_len=0, key 2b7e151628aed2a6abf7158809cf4f3c, plain 3243f6a8885a308d313198a2e0370734 -> cipher 3925841d02dc09fbdc118597196a0b32. key_ready rises 41 cycles after key_load; out_valid rises 10 cycles after accept (UNROLL=1).
- FIPS-197 C.2: key_len=1, key 000102…17, plain 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191, with latency 12.
- FIPS-197 C.3: key_len=2, key 000102…1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089. Repeat with UNROLL=2 -> same cipher, latency 7.
- Backpressure and key reuse: hold out_ready=0 for 20 cycles.
  - Required: cipher is stable, in_ready=0, and key_load is ignored throughout.
  - Then release and send C.1 plaintext under key 000102…0f -> 69c4e0d86a7b0430d8cdb78070b4c55a, with no re-expansion.
- Reset mid-RUN: assert rst_n=0 at round 5.
  - Required: the next cycle shows out_valid=0, key_ready=0, key_load_ready=1, in_ready=0.
  - After reloading the key, the C.3 vector passes.
- Simultaneous key_load and in_valid in IDLE: the block is not accepted and re-expansion starts. After key_ready, the block is accepted and produces the cipher for the new key.
